// File: rtl/nway_wb_cache_if.sv
// ---------------------------------------------------------------------------
// nway_wb_cache_if
// Bus bundle for the N-way write-back cache: the CPU request/response port
// and the word-wide memory port, which has a fixed 1-cycle read latency.
//
//   CPU side   : cpu_add, cpu_data_in, cpu_ren, cpu_wen     (to cache)
//                cpu_ready, cpu_valid, hit_miss, cpu_data_out (from cache)
//   Memory side: m_rd_address, m_ren, m_wr_address, m_wen, m_data_out
//                (from cache), m_data_in (to cache, 1 cycle after m_ren)
//
// Modports: slave = the cache, master = CPU + memory environment.
// ---------------------------------------------------------------------------
interface nway_wb_cache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 12
);
    logic [ADD_WIDTH-1:0]  cpu_add;
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic                  cpu_ren;
    logic                  cpu_wen;
    logic                  cpu_ready;
    logic                  cpu_valid;
    logic                  hit_miss;
    logic [DATA_WIDTH-1:0] cpu_data_out;
    logic [ADD_WIDTH-1:0]  m_rd_address;
    logic                  m_ren;
    logic [DATA_WIDTH-1:0] m_data_in;
    logic [ADD_WIDTH-1:0]  m_wr_address;
    logic                  m_wen;
    logic [DATA_WIDTH-1:0] m_data_out;

    modport slave (
        input  cpu_add, cpu_data_in, cpu_ren, cpu_wen, m_data_in,
        output cpu_ready, cpu_valid, hit_miss, cpu_data_out,
               m_rd_address, m_ren, m_wr_address, m_wen, m_data_out
    );

    modport master (
        output cpu_add, cpu_data_in, cpu_ren, cpu_wen, m_data_in,
        input  cpu_ready, cpu_valid, hit_miss, cpu_data_out,
               m_rd_address, m_ren, m_wr_address, m_wen, m_data_out
    );
endinterface

// File: rtl/nway_wb_cache.sv
// ---------------------------------------------------------------------------
// nway_wb_cache
// Parametrised N-way set-associative, write-back / write-allocate cache with
// true-LRU replacement and multi-word lines.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high; clears valid/dirty, restores LRU ages
//   bus    : nway_wb_cache_if.slave (CPU handshake + word-wide memory port)
//
// Address split: {tag, index, offset}, offset = log2(WORDS_PER_LINE) bits,
// index = log2(NSETS) bits, tag = the rest.
// Every bus output is a register; cpu_ready is only high in IDLE.
// ---------------------------------------------------------------------------
module nway_wb_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADD_WIDTH      = 12,
    parameter int NWAYS          = 4,
    parameter int NSETS          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic            clock,
    input  logic            reset,
    nway_wb_cache_if.slave  bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = ADD_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(NWAYS);
    localparam int CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] REFILL_END = CNT_W'(WORDS_PER_LINE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
    } state_t;

    // Line storage and per-line metadata
    logic [DATA_WIDTH-1:0] data_q [NWAYS][NSETS][WORDS_PER_LINE];
    logic [TAG_W-1:0]      tag_q  [NWAYS][NSETS];
    logic [NWAYS-1:0]      valid_q [NSETS];
    logic [NWAYS-1:0]      dirty_q [NSETS];
    logic [WAY_W-1:0]      age_q   [NSETS][NWAYS];

    // Request and control registers
    state_t                state_q;
    logic [TAG_W-1:0]      req_tag_q;
    logic [IDX_W-1:0]      req_idx_q;
    logic [OFF_W-1:0]      req_off_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  req_write_q;
    logic [WAY_W-1:0]      way_q;
    logic                  hit_q;
    logic [CNT_W-1:0]      cnt_q;

    // Registered outputs
    logic                  cpu_ready_q;
    logic                  cpu_valid_q;
    logic                  hit_miss_q;
    logic [DATA_WIDTH-1:0] cpu_data_out_q;
    logic [ADD_WIDTH-1:0]  m_rd_addr_q;
    logic                  m_ren_q;
    logic [ADD_WIDTH-1:0]  m_wr_addr_q;
    logic                  m_wen_q;
    logic [DATA_WIDTH-1:0] m_wdata_q;

    logic                  hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [WAY_W-1:0]      victim_s;
    logic [OFF_W-1:0]      next_off_s;
    logic [OFF_W-1:0]      prev_off_s;
    logic                  lru_en_s;
    logic [WAY_W-1:0]      lru_way_s;

    // Tag compare, victim choice and LRU touch selection for the current request
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        victim_s  = '0;
        // Oldest way first; a lower-index invalid way then overrides it.
        for (int w = 0; w < NWAYS; w++) begin
            victim_s = (age_q[req_idx_q][w] == WAY_W'(NWAYS - 1)) ? WAY_W'(w) : victim_s;
        end
        for (int w = NWAYS - 1; w >= 0; w--) begin
            victim_s = (!valid_q[req_idx_q][w]) ? WAY_W'(w) : victim_s;
        end
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[req_idx_q][w] && (tag_q[w][req_idx_q] == req_tag_q)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_s     = hit_s;
            end
        end
        next_off_s = OFF_W'(cnt_q + CNT_W'(1));
        prev_off_s = OFF_W'(cnt_q - CNT_W'(1));
        lru_en_s   = ((state_q == S_LOOKUP) && hit_s) ||
                     ((state_q == S_REFILL) && (cnt_q == REFILL_END));
        lru_way_s  = (state_q == S_LOOKUP) ? hit_way_s : way_q;
    end

    // Controller FSM, line/metadata updates and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            req_tag_q      <= '0;
            req_idx_q      <= '0;
            req_off_q      <= '0;
            req_wdata_q    <= '0;
            req_write_q    <= 1'b0;
            way_q          <= '0;
            hit_q          <= 1'b0;
            cnt_q          <= '0;
            cpu_ready_q    <= 1'b0;
            cpu_valid_q    <= 1'b0;
            hit_miss_q     <= 1'b0;
            cpu_data_out_q <= '0;
            m_rd_addr_q    <= '0;
            m_ren_q        <= 1'b0;
            m_wr_addr_q    <= '0;
            m_wen_q        <= 1'b0;
            m_wdata_q      <= '0;
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NWAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    cpu_valid_q <= 1'b0;
                    hit_miss_q  <= 1'b0;
                    if (cpu_ready_q && (bus.cpu_ren || bus.cpu_wen)) begin
                        req_off_q   <= bus.cpu_add[OFF_W-1:0];
                        req_idx_q   <= bus.cpu_add[OFF_W +: IDX_W];
                        req_tag_q   <= bus.cpu_add[ADD_WIDTH-1 -: TAG_W];
                        req_wdata_q <= bus.cpu_data_in;
                        req_write_q <= bus.cpu_wen;   // ren & wen together is a write
                        cpu_ready_q <= 1'b0;
                        state_q     <= S_LOOKUP;
                    end else begin
                        cpu_ready_q <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    cnt_q <= '0;
                    if (hit_s) begin
                        way_q   <= hit_way_s;
                        hit_q   <= 1'b1;
                        state_q <= S_RESPOND;
                    end else begin
                        way_q <= victim_s;
                        hit_q <= 1'b0;
                        if (valid_q[req_idx_q][victim_s] && dirty_q[req_idx_q][victim_s]) begin
                            m_wen_q     <= 1'b1;
                            m_wr_addr_q <= {tag_q[victim_s][req_idx_q], req_idx_q, OFF_W'(0)};
                            m_wdata_q   <= data_q[victim_s][req_idx_q][OFF_W'(0)];
                            state_q     <= S_WRITEBACK;
                        end else begin
                            m_ren_q     <= 1'b1;
                            m_rd_addr_q <= {req_tag_q, req_idx_q, OFF_W'(0)};
                            state_q     <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (cnt_q == LAST_WORD) begin
                        // Refill issue starts right after the last write beat.
                        m_wen_q     <= 1'b0;
                        cnt_q       <= '0;
                        m_ren_q     <= 1'b1;
                        m_rd_addr_q <= {req_tag_q, req_idx_q, OFF_W'(0)};
                        state_q     <= S_REFILL;
                    end else begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        m_wr_addr_q <= {tag_q[way_q][req_idx_q], req_idx_q, next_off_s};
                        m_wdata_q   <= data_q[way_q][req_idx_q][next_off_s];
                    end
                end
                S_REFILL: begin
                    // Word k arrives one cycle after its issue, i.e. at count k+1.
                    if (cnt_q != '0) begin
                        data_q[way_q][req_idx_q][prev_off_s] <= bus.m_data_in;
                    end
                    if (cnt_q == REFILL_END) begin
                        valid_q[req_idx_q][way_q] <= 1'b1;
                        dirty_q[req_idx_q][way_q] <= 1'b0;
                        tag_q[way_q][req_idx_q]   <= req_tag_q;
                        state_q                   <= S_RESPOND;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q < LAST_WORD) begin
                            m_ren_q     <= 1'b1;
                            m_rd_addr_q <= {req_tag_q, req_idx_q, next_off_s};
                        end else begin
                            m_ren_q     <= 1'b0;
                        end
                    end
                end
                S_RESPOND: begin
                    cpu_valid_q <= 1'b1;
                    hit_miss_q  <= hit_q;
                    cpu_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                    if (req_write_q) begin
                        data_q[way_q][req_idx_q][req_off_q] <= req_wdata_q;
                        dirty_q[req_idx_q][way_q]           <= 1'b1;
                        cpu_data_out_q                      <= req_wdata_q;
                    end else begin
                        cpu_data_out_q <= data_q[way_q][req_idx_q][req_off_q];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // True LRU: younger ways age by one, the touched way becomes 0.
            if (lru_en_s) begin
                for (int i = 0; i < NWAYS; i++) begin
                    if (age_q[req_idx_q][i] < age_q[req_idx_q][lru_way_s]) begin
                        age_q[req_idx_q][i] <= age_q[req_idx_q][i] + WAY_W'(1);
                    end
                end
                age_q[req_idx_q][lru_way_s] <= '0;
            end
        end
    end

    assign bus.cpu_ready    = cpu_ready_q;
    assign bus.cpu_valid    = cpu_valid_q;
    assign bus.hit_miss     = hit_miss_q;
    assign bus.cpu_data_out = cpu_data_out_q;
    assign bus.m_rd_address = m_rd_addr_q;
    assign bus.m_ren        = m_ren_q;
    assign bus.m_wr_address = m_wr_addr_q;
    assign bus.m_wen        = m_wen_q;
    assign bus.m_data_out   = m_wdata_q;

endmodule

// File: tb/tb_nway_wb_cache.sv
// ---------------------------------------------------------------------------
// tb_nway_wb_cache
// Drives nway_wb_cache with directed and random requests against a 1-cycle
// latency word memory. Expected results come from a line-level reference
// model (timestamp LRU, explicit line copies, reference memory image).
// ---------------------------------------------------------------------------
module tb_nway_wb_cache;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NW  = 4;
    localparam int NS  = 64;
    localparam int WPL = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    nway_wb_cache_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();

    nway_wb_cache #(
        .DATA_WIDTH(DW), .ADD_WIDTH(AW), .NWAYS(NW), .NSETS(NS), .WORDS_PER_LINE(WPL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Environment memory
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clock) begin
        if (bus.m_ren) bus.m_data_in <= mem[bus.m_rd_address];
        if (bus.m_wen) mem[bus.m_wr_address] <= bus.m_data_out;
    end

    // Memory traffic monitor
    int obs_rd_q[$];
    int obs_wr_q[$];
    int overlap_cnt = 0;
    always @(negedge clock) begin
        if (bus.m_ren) obs_rd_q.push_back(int'(bus.m_rd_address));
        if (bus.m_wen) obs_wr_q.push_back(int'(bus.m_wr_address));
        if (bus.m_ren && bus.m_wen) overlap_cnt++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference model
    logic [DW-1:0] ref_mem [1 << AW];
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];
    int            m_tag   [NS][NW];
    logic [DW-1:0] m_line  [NS][NW][WPL];
    int            m_stamp [NS][NW];
    int            m_now = 0;
    int            exp_rd_q[$];
    int            exp_wb_q[$];

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_stamp[s][w] = -w;   // way 0 most recent, way NW-1 least
            end
        end
    endtask

    task automatic model_access(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                                output bit hit, output logic [DW-1:0] rdata, output int lat);
        int s, t, o, way;
        bit wb;
        s = int'(a[7:2]);
        t = int'(a[11:8]);
        o = int'(a[1:0]);
        exp_rd_q.delete();
        exp_wb_q.delete();
        hit = 1'b0;
        way = -1;
        wb  = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                hit = 1'b1;
                way = w;
            end
        end
        if (!hit) begin
            for (int w = NW - 1; w >= 0; w--) begin
                if (!m_valid[s][w]) way = w;
            end
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < NW; w++) begin
                    if (m_stamp[s][w] < m_stamp[s][way]) way = w;
                end
            end
            if (m_valid[s][way] && m_dirty[s][way]) begin
                wb = 1'b1;
                for (int k = 0; k < WPL; k++) begin
                    exp_wb_q.push_back(m_tag[s][way] * NS * WPL + s * WPL + k);
                    ref_mem[m_tag[s][way] * NS * WPL + s * WPL + k] = m_line[s][way][k];
                end
            end
            for (int k = 0; k < WPL; k++) begin
                exp_rd_q.push_back(t * NS * WPL + s * WPL + k);
                m_line[s][way][k] = ref_mem[t * NS * WPL + s * WPL + k];
            end
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = t;
        end
        m_now++;
        m_stamp[s][way] = m_now;
        if (wr) begin
            m_line[s][way][o] = wd;
            m_dirty[s][way]   = 1'b1;
            rdata             = wd;
        end else begin
            rdata = m_line[s][way][o];
        end
        lat = hit ? 2 : (2 + WPL + 1 + (wb ? WPL : 0));
    endtask

    // One CPU transaction; entered and left at a falling edge.
    task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit ren,
                          input bit wen, input bit pulse,
                          output logic [DW-1:0] got_data, output bit got_hit);
        bit            e_hit;
        logic [DW-1:0] e_data;
        int            e_lat, n, waitc, nr, nw;
        bit            got;
        model_access(a, wen, wd, e_hit, e_data, e_lat);
        waitc = 0;
        while (!bus.cpu_ready && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        check_eq("ready_before_req", 32'(bus.cpu_ready), 32'd1);
        bus.cpu_add     = a;
        bus.cpu_data_in = wd;
        bus.cpu_ren     = ren;
        bus.cpu_wen     = wen;
        obs_rd_q.delete();
        obs_wr_q.delete();
        @(posedge clock);
        @(negedge clock);
        if (pulse) begin
            bus.cpu_ren = 1'b1;
            bus.cpu_wen = 1'b0;
            bus.cpu_add = a ^ 12'h100;
        end else begin
            bus.cpu_ren = 1'b0;
            bus.cpu_wen = 1'b0;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            bus.cpu_ren = 1'b0;
            bus.cpu_wen = 1'b0;
            if (bus.cpu_valid) got = 1'b1;
        end
        check_eq("resp_seen", 32'(got), 32'd1);
        check_eq("latency", 32'(n), 32'(e_lat));
        check_eq("hit_miss", 32'(bus.hit_miss), 32'(e_hit));
        check_eq("data_out", bus.cpu_data_out, e_data);
        check_eq("n_mem_reads", 32'(obs_rd_q.size()), 32'(exp_rd_q.size()));
        check_eq("n_mem_writes", 32'(obs_wr_q.size()), 32'(exp_wb_q.size()));
        nr = (obs_rd_q.size() < exp_rd_q.size()) ? obs_rd_q.size() : exp_rd_q.size();
        nw = (obs_wr_q.size() < exp_wb_q.size()) ? obs_wr_q.size() : exp_wb_q.size();
        for (int i = 0; i < nr; i++) check_eq("rd_addr", 32'(obs_rd_q[i]), 32'(exp_rd_q[i]));
        for (int i = 0; i < nw; i++) check_eq("wr_addr", 32'(obs_wr_q[i]), 32'(exp_wb_q[i]));
        got_data = bus.cpu_data_out;
        got_hit  = bus.hit_miss;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit h);
        do_req(a, 32'h0, 1'b1, 1'b0, 1'b0, d, h);
    endtask

    initial begin
        logic [DW-1:0] d;
        bit            h;
        int            extra, waitc, diffs;
        logic [AW-1:0] ra;

        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]     = 32'hA000_0000 + 32'(a);
            ref_mem[a] = 32'hA000_0000 + 32'(a);
        end
        bus.cpu_add     = '0;
        bus.cpu_data_in = '0;
        bus.cpu_ren     = 1'b0;
        bus.cpu_wen     = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst_ready", 32'(bus.cpu_ready), 32'd0);
        check_eq("rst_valid", 32'(bus.cpu_valid), 32'd0);
        check_eq("rst_hit", 32'(bus.hit_miss), 32'd0);
        check_eq("rst_data", bus.cpu_data_out, 32'd0);
        check_eq("rst_m_ren", 32'(bus.m_ren), 32'd0);
        check_eq("rst_m_wen", 32'(bus.m_wen), 32'd0);
        check_eq("rst_rd_addr", 32'(bus.m_rd_address), 32'd0);
        check_eq("rst_wr_addr", 32'(bus.m_wr_address), 32'd0);
        check_eq("rst_m_data", bus.m_data_out, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("ready_after_rst", 32'(bus.cpu_ready), 32'd1);

        // Cold miss then hit in the same line
        rd(12'h0AB, d, h);
        check_eq("t1_miss_data", d, 32'hA000_00AB);
        check_eq("t1_miss_flag", 32'(h), 32'd0);
        rd(12'h0A9, d, h);
        check_eq("t1_hit_flag", 32'(h), 32'd1);

        // Write hit stays in cache
        do_req(12'h0AB, 32'hBADD_BEEF, 1'b0, 1'b1, 1'b0, d, h);
        rd(12'h0AB, d, h);
        check_eq("t2_read_back", d, 32'hBADD_BEEF);
        check_eq("t2_mem_unchanged", mem[12'h0AB], 32'hA000_00AB);

        // Fill the set, then force a dirty eviction
        rd(12'h1A8, d, h);
        rd(12'h2A8, d, h);
        rd(12'h3A8, d, h);
        rd(12'h4A8, d, h);
        check_eq("t3_data", d, 32'hA000_04A8);
        check_eq("t3_mem_written", mem[12'h0AB], 32'hBADD_BEEF);

        // LRU victim choice
        rd(12'h1A8, d, h);
        rd(12'h5A8, d, h);
        rd(12'h1A8, d, h);
        check_eq("t4_1a8_hit", 32'(h), 32'd1);
        rd(12'h2A8, d, h);
        check_eq("t4_2a8_miss", 32'(h), 32'd0);

        // ren & wen together is a write; a request while busy is ignored
        do_req(12'h5A9, 32'h1234_5678, 1'b1, 1'b1, 1'b1, d, h);
        check_eq("t5_wdata_echo", d, 32'h1234_5678);
        extra = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.cpu_valid) extra++;
        end
        check_eq("t5_no_extra_resp", 32'(extra), 32'd0);
        rd(12'h5A9, d, h);
        check_eq("t5_read_back", d, 32'h1234_5678);

        // Reset in the middle of a refill
        bus.cpu_add = 12'h6B4;
        bus.cpu_ren = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.cpu_ren = 1'b0;
        waitc = 0;
        while (!bus.m_ren && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        check_eq("t6_refill_started", 32'(bus.m_ren), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_eq("t6_m_ren_off", 32'(bus.m_ren), 32'd0);
        check_eq("t6_valid_off", 32'(bus.cpu_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        extra = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus.cpu_valid) extra++;
        end
        check_eq("t6_no_resp", 32'(extra), 32'd0);
        check_eq("t6_ready", 32'(bus.cpu_ready), 32'd1);
        rd(12'h1A8, d, h);
        check_eq("t6_miss_after_rst", 32'(h), 32'd0);

        // Random traffic over two sets with many tags
        for (int i = 0; i < 250; i++) begin
            bit wen, ren, pl;
            ra  = AW'(($urandom_range(0, 7) << 8) | (($urandom_range(0, 1) + 16) << 2) |
                      $urandom_range(0, 3));
            wen = ($urandom_range(0, 9) < 4);
            ren = !wen || ($urandom_range(0, 3) == 0);
            pl  = ($urandom_range(0, 15) == 0);
            do_req(ra, DW'($urandom), ren, wen, pl, d, h);
        end

        repeat (3) @(negedge clock);
        diffs = 0;
        for (int a = 0; a < (1 << AW); a++) begin
            if (mem[a] !== ref_mem[a]) diffs++;
        end
        check_eq("mem_image", 32'(diffs), 32'd0);
        check_eq("ren_wen_overlap", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nway_wb_cache.md
Name: nway_wb_cache

Overview:
- Parametrised N-way set-associative cache with true-LRU replacement.
- Write-back, write-allocate policy with per-line dirty bits.
- Multi-word lines and a ready/valid CPU handshake.
- Sits between the CPU port and the word-wide `mem` block, which has a fixed 1-cycle read latency. It is the successor to the fixed 2-way i_cache and supports arbitrary ways, sets and line size.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADD_WIDTH, 12, word address width.
- NWAYS, 4, associativity; power of 2, ≥2.
- NSETS, 64, number of sets; power of 2.
- WORDS_PER_LINE, 4, words per line; power of 2, ≥2.
- Address split: offset = low log2(WORDS_PER_LINE) bits, index = next log2(NSETS) bits, tag = remaining bits (must be ≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_add  in  ADD_WIDTH  request word address.
- cpu_data_in  in  DATA_WIDTH  write data.
- cpu_ren  in  1  read request.
- cpu_wen  in  1  write request.
- cpu_ready  out  1  cache can accept a request.
- cpu_valid  out  1  one-cycle response strobe.
- hit_miss  out  1  valid with cpu_valid: 1 = hit, 0 = miss.
- cpu_data_out  out  DATA_WIDTH  read data, or the written data for a write.
- m_rd_address  out  ADD_WIDTH  memory read address.
- m_ren  out  1  memory read enable.
- m_data_in  in  DATA_WIDTH  memory read data, valid 1 cycle after m_ren.
- m_wr_address  out  ADD_WIDTH  memory write address.
- m_wen  out  1  memory write enable.
- m_data_out  out  DATA_WIDTH  memory write data.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high.
  - While reset is high: all valid and dirty bits are cleared; LRU age of way i in every set = i; FSM → IDLE.
  - Output values during reset: cpu_ready=0, cpu_valid=0, hit_miss=0, cpu_data_out=0, m_ren=0, m_wen=0, all addresses and m_data_out = 0.
- Handshake:
  - cpu_ready=1 only in IDLE.
  - A request is accepted at an edge where cpu_ready & (cpu_ren | cpu_wen).
  - Address and data are registered at acceptance. Requests while cpu_ready=0 are ignored, not queued.
  - If cpu_ren and cpu_wen are both high, the request is treated as a write.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
  - IDLE → LOOKUP on accept.
  - LOOKUP compares the tag in all ways of the indexed set (valid & tag match).
    - Hit → RESPOND with hit_miss=1.
    - Miss → select a victim: the lowest-index invalid way, else the way with age NWAYS-1. Go to WRITEBACK if the victim is valid & dirty, else REFILL.
  - WRITEBACK: WORDS_PER_LINE consecutive cycles, m_wen=1. Write k goes to {victim tag, index, k} with the line's word k, k = 0..W-1. Then → REFILL.
  - REFILL: m_ren=1 on W consecutive cycles at {req tag, index, k}. Word k is captured from m_data_in the cycle after its issue (W+1 cycles total). Then set valid=1, dirty=0, tag=req tag, and → RESPOND with hit_miss=0.
  - RESPOND: one cycle, cpu_valid=1.
    - Read: cpu_data_out = line word at the request offset.
    - Write: the word is updated, dirty=1, cpu_data_out = written data.
    - Then → IDLE.
- Latency:
  - Hit: cpu_valid is high in the cycle after the 2nd edge following acceptance, giving a 3-cycle issue interval.
  - Clean miss: 2 + (W+1) cycles.
  - Dirty miss: adds W cycles.
- LRU update (on every hit, and after a refill for the accessed way w):
  - Ways with age < age[w] increment; age[w]=0.
  - Ages in a set always form a permutation of 0..NWAYS-1.
- Memory enables: m_ren and m_wen are never high in the same cycle. Both are 0 outside WRITEBACK/REFILL.
- Reset mid-operation: the transaction is abandoned with no further m_ren/m_wen, and dirty data is lost. No cpu_valid is issued for the aborted request.

Test Plan (defaults NWAYS=4, NSETS=64, WPL=4; index = addr[7:2]; memory preloaded mem[a]=32'hA000_0000+a):
1. Read 0x0AB after reset → m_ren at 0x0A8..0x0AB, no m_wen, cpu_valid with hit_miss=0, data A00000AB. Then read 0x0A9 → hit_miss=1, data A00000A9, cpu_valid exactly 2 edges after accept.
2. Write 0x0AB = BADDBEEF → hit. Read 0x0AB → BADDBEEF. mem[0x0AB] is still A00000AB (not yet written back).
3. Read 0x1A8, 0x2A8, 0x3A8 → three misses, no m_wen. Then read 0x4A8 → 4 m_wen at 0x0A8..0x0AB, mem[0x0AB]=BADDBEEF afterwards, refill from 0x4A8..0x4AB, data A00004A8.
4. Read 0x1A8 (hit), then read 0x5A8 → evicts the 0x2A8 line (clean, no m_wen). Read 0x1A8 → hit; read 0x2A8 → miss.
5. Assert cpu_ren=cpu_wen=1 at 0x5A9 with data 12345678 → treated as a write, cpu_data_out=12345678, and a later read returns it. A request pulsed while cpu_ready=0 produces no response.
6. Assert reset during REFILL → m_ren=0 and cpu_valid=0 from the next edge, cpu_ready=1 after release. A subsequent read of 0x1A8 → miss.
